// File: rtl/trap_nest_ctrl_if.sv
// Trap controller bus: exception/interrupt/mret/MIE inputs from the core and
// CSR file, plus the trap state reported back. The controller takes the
// slave modport; the core-side driver takes the master modport.
interface trap_nest_ctrl_if #(
  parameter int NUM_IRQ    = 4,
  parameter int NEST_DEPTH = 2
);
  localparam int DW = $clog2(NEST_DEPTH + 1);

  logic               i_exc_req;
  logic [3:0]         i_exc_cause;
  logic [NUM_IRQ-1:0] i_irq_pending;
  logic [NUM_IRQ-1:0] i_irq_enable;
  logic               i_mret;
  logic               i_mie_wr;
  logic               i_mie_wdata;
  logic               o_trap_mode;
  logic               o_flush;
  logic               o_trap_take;
  logic [4:0]         o_cause;
  logic               o_is_irq;
  logic               o_mie;
  logic [DW-1:0]      o_depth;
  logic               o_halt;

  modport master (
    output i_exc_req, i_exc_cause, i_irq_pending, i_irq_enable,
           i_mret, i_mie_wr, i_mie_wdata,
    input  o_trap_mode, o_flush, o_trap_take, o_cause, o_is_irq,
           o_mie, o_depth, o_halt
  );

  modport slave (
    input  i_exc_req, i_exc_cause, i_irq_pending, i_irq_enable,
           i_mret, i_mie_wr, i_mie_wdata,
    output o_trap_mode, o_flush, o_trap_take, o_cause, o_is_irq,
           o_mie, o_depth, o_halt
  );
endinterface

// File: rtl/trap_nest_ctrl.sv
// Machine-mode trap controller with nesting: prioritised exception/interrupt
// selection, timed flush before entry, nesting-depth counter and a stack of
// saved MIE bits that mret unwinds.
// Optional feature macro: TRAP_DOUBLE_FAULT_HALT_EN -- when defined, an
// exception at full nesting depth halts the core (o_halt, flush held) until
// reset; otherwise it is taken with depth saturated and the stack untouched.
module trap_nest_ctrl #(
  parameter int NUM_IRQ      = 4,
  parameter int NEST_DEPTH   = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  trap_nest_ctrl_if.slave bus
);
  localparam int DW = $clog2(NEST_DEPTH + 1);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [DW-1:0] MAX_DEPTH  = DW'(NEST_DEPTH);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {RUN, FLUSH, ENTER, HALT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4:0]            cause_q, cause_d;
  logic                  is_irq_q, is_irq_d;
  logic                  mie_q, mie_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic [NEST_DEPTH-1:0] stack_q, stack_d;
  logic                  flush_q, flush_d;
  logic                  take_q, take_d;
  logic                  mode_q, mode_d;
  logic                  halt_q, halt_d;

  logic [NUM_IRQ-1:0]    irq_elig;
  logic                  irq_any;
  logic [4:0]            irq_idx;
  logic                  pop_bit;
  logic                  room;

  // Interrupts only compete while MIE is set and another nesting level is free.
  assign room = (depth_q < MAX_DEPTH);

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_elig
      assign irq_elig[gi] = bus.i_irq_pending[gi] & bus.i_irq_enable[gi] & mie_q & room;
    end
  endgenerate

  // Lowest eligible interrupt index wins; stack top is the entry below depth.
  always_comb begin
    irq_any = |irq_elig;
    irq_idx = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_elig[i]) irq_idx = 5'(i);
    end
    pop_bit = 1'b0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) pop_bit = stack_q[i];
    end
  end

  // Next-state logic: acceptance beats mret, which beats an MIE write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    is_irq_d = is_irq_q;
    mie_d    = mie_q;
    depth_d  = depth_q;
    stack_d  = stack_q;
    halt_d   = halt_q;
    case (state_q)
      RUN: begin
        if (bus.i_exc_req) begin
          state_d  = FLUSH;
          cnt_d    = FLUSH_LOAD;
          cause_d  = {1'b0, bus.i_exc_cause};
          is_irq_d = 1'b0;
        end else if (irq_any) begin
          state_d  = FLUSH;
          cnt_d    = FLUSH_LOAD;
          cause_d  = irq_idx;
          is_irq_d = 1'b1;
        end else if (bus.i_mret && depth_q != '0) begin
          mie_d   = pop_bit;
          depth_d = depth_q - 1'b1;
        end else if (bus.i_mie_wr) begin
          mie_d = bus.i_mie_wdata;
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(1)) begin
`ifdef TRAP_DOUBLE_FAULT_HALT_EN
          // Only an exception can be accepted at full depth, so this is a double fault.
          if (depth_q == MAX_DEPTH) begin
            state_d = HALT;
            halt_d  = 1'b1;
          end else begin
            state_d = ENTER;
          end
`else
          state_d = ENTER;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ENTER: begin
        state_d = RUN;
        mie_d   = 1'b0;
        // At full depth the stack top is preserved and depth saturates.
        if (depth_q != MAX_DEPTH) begin
          for (int i = 0; i < NEST_DEPTH; i++) begin
            if (depth_q == DW'(i)) stack_d[i] = mie_q;
          end
          depth_d = depth_q + 1'b1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    flush_d = (state_d == FLUSH) || (state_d == HALT);
    take_d  = (state_d == ENTER);
    mode_d  = (depth_d != '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      cause_q  <= '0;
      is_irq_q <= 1'b0;
      mie_q    <= 1'b0;
      depth_q  <= '0;
      stack_q  <= '0;
      flush_q  <= 1'b0;
      take_q   <= 1'b0;
      mode_q   <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      is_irq_q <= is_irq_d;
      mie_q    <= mie_d;
      depth_q  <= depth_d;
      stack_q  <= stack_d;
      flush_q  <= flush_d;
      take_q   <= take_d;
      mode_q   <= mode_d;
      halt_q   <= halt_d;
    end
  end

  assign bus.o_trap_mode = mode_q;
  assign bus.o_flush     = flush_q;
  assign bus.o_trap_take = take_q;
  assign bus.o_cause     = cause_q;
  assign bus.o_is_irq    = is_irq_q;
  assign bus.o_mie       = mie_q;
  assign bus.o_depth     = depth_q;
`ifdef TRAP_DOUBLE_FAULT_HALT_EN
  assign bus.o_halt      = halt_q;
`else
  assign bus.o_halt      = 1'b0;
`endif
endmodule

// File: tb/tb_trap_nest_ctrl.sv
// Self-checking bench for trap_nest_ctrl: stimulus tasks push expected trap
// entries (cause, kind, cycle) to a scoreboard; a monitor pops and compares on
// every o_trap_take pulse. State checks are done inline in each task.
module tb_trap_nest_ctrl;
  localparam int NUM_IRQ = 4;
  localparam int NEST    = 2;
  localparam int FC      = 2;
  localparam int DW      = $clog2(NEST + 1);

  typedef struct {
    logic [4:0] cause;
    logic       is_irq;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total_cnt = 0;
  int   pass_cnt = 0;
  exp_t sb_q[$];

  trap_nest_ctrl_if #(.NUM_IRQ(NUM_IRQ), .NEST_DEPTH(NEST)) tif ();

  trap_nest_ctrl #(.NUM_IRQ(NUM_IRQ), .NEST_DEPTH(NEST), .FLUSH_CYCLES(FC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (tif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every trap entry must match the oldest expectation.
  always @(negedge clk) begin
    if (tif.o_trap_take === 1'b1) begin
      total_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL take_unexpected: got o_trap_take=1 cause=%0d at cycle %0d, required no trap", tif.o_cause, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (tif.o_cause !== e.cause || tif.o_is_irq !== e.is_irq || cyc != e.cyc) begin
          $display("FAIL take_match: got cause=%0d irq=%0b cycle=%0d, required cause=%0d irq=%0b cycle=%0d",
                   tif.o_cause, tif.o_is_irq, cyc, e.cause, e.is_irq, e.cyc);
        end else begin
          pass_cnt++;
          $display("take: cause=%0d irq=%0b cycle=%0d", tif.o_cause, tif.o_is_irq, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tif.i_exc_req     = 1'b0;
    tif.i_exc_cause   = 4'd0;
    tif.i_irq_pending = '0;
    tif.i_irq_enable  = '0;
    tif.i_mret        = 1'b0;
    tif.i_mie_wr      = 1'b0;
    tif.i_mie_wdata   = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] cause, input logic is_irq);
    exp_t e;
    e.cause  = cause;
    e.is_irq = is_irq;
    e.cyc    = cyc + FC + 1;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    outs = {tif.o_trap_mode, tif.o_flush, tif.o_trap_take, tif.o_cause, tif.o_is_irq,
            tif.o_mie, 2'(tif.o_depth), tif.o_halt};
    total_cnt++;
    if (outs !== 14'd0) $display("FAIL reset_outputs: got %b, required all zero", outs);
    else pass_cnt++;
  endtask

  task automatic test_exception_single();
    tif.i_exc_req = 1'b1;
    tif.i_exc_cause = 4'd2;
    push_exp(5'd2, 1'b0);
    tick();
    tif.i_exc_req = 1'b0;
    for (int i = 0; i < FC; i++) begin
      total_cnt++;
      if (tif.o_flush !== 1'b1 || tif.o_trap_take !== 1'b0)
        $display("FAIL exc_flush: got flush=%b take=%b in flush cycle %0d, required 1/0", tif.o_flush, tif.o_trap_take, i);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (tif.o_flush !== 1'b0 || tif.o_depth !== DW'(0))
      $display("FAIL exc_enter: got flush=%b depth=%0d during entry, required 0/0", tif.o_flush, tif.o_depth);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (tif.o_depth !== DW'(1) || tif.o_trap_mode !== 1'b1 || tif.o_mie !== 1'b0 || tif.o_trap_take !== 1'b0)
      $display("FAIL exc_after: got depth=%0d mode=%b mie=%b take=%b, required 1/1/0/0",
               tif.o_depth, tif.o_trap_mode, tif.o_mie, tif.o_trap_take);
    else pass_cnt++;
    // Unwind: stack[0] held MIE=0.
    tif.i_mret = 1'b1;
    tick();
    tif.i_mret = 1'b0;
    total_cnt++;
    if (tif.o_depth !== DW'(0) || tif.o_trap_mode !== 1'b0 || tif.o_mie !== 1'b0)
      $display("FAIL exc_mret: got depth=%0d mode=%b mie=%b, required 0/0/0", tif.o_depth, tif.o_trap_mode, tif.o_mie);
    else pass_cnt++;
  endtask

  task automatic test_irq_priority();
    int flush_seen;
    tif.i_mie_wr = 1'b1;
    tif.i_mie_wdata = 1'b1;
    tick();
    tif.i_mie_wr = 1'b0;
    total_cnt++;
    if (tif.o_mie !== 1'b1) $display("FAIL mie_write: got %b, required 1", tif.o_mie);
    else pass_cnt++;
    tif.i_irq_pending = 4'b1010;
    tif.i_irq_enable  = 4'b1110;
    push_exp(5'd1, 1'b1);
    tick();
    tif.i_irq_pending = '0;
    repeat (FC + 1) tick();
    total_cnt++;
    if (tif.o_cause !== 5'd1 || tif.o_is_irq !== 1'b1 || tif.o_depth !== DW'(1) || tif.o_mie !== 1'b0)
      $display("FAIL irq_prio: got cause=%0d irq=%b depth=%0d mie=%b, required 1/1/1/0",
               tif.o_cause, tif.o_is_irq, tif.o_depth, tif.o_mie);
    else pass_cnt++;
    tif.i_mret = 1'b1;
    tick();
    tif.i_mret = 1'b0;
    total_cnt++;
    if (tif.o_mie !== 1'b1 || tif.o_depth !== DW'(0))
      $display("FAIL irq_mret: got mie=%b depth=%0d, required 1/0", tif.o_mie, tif.o_depth);
    else pass_cnt++;
    // Same lines with MIE cleared: nothing must be taken.
    tif.i_mie_wr = 1'b1;
    tif.i_mie_wdata = 1'b0;
    tick();
    tif.i_mie_wr = 1'b0;
    tif.i_irq_pending = 4'b1010;
    flush_seen = 0;
    repeat (FC + 4) begin
      tick();
      if (tif.o_flush === 1'b1) flush_seen++;
    end
    tif.i_irq_pending = '0;
    total_cnt++;
    if (flush_seen != 0 || tif.o_depth !== DW'(0))
      $display("FAIL irq_masked: got flush cycles=%0d depth=%0d, required 0/0", flush_seen, tif.o_depth);
    else pass_cnt++;
  endtask

  task automatic test_nesting_mret();
    tif.i_mie_wr = 1'b1;
    tif.i_mie_wdata = 1'b1;
    tick();
    tif.i_mie_wr = 1'b0;
    tif.i_irq_enable = 4'b0101;
    tif.i_irq_pending = 4'b0100;
    push_exp(5'd2, 1'b1);
    tick();
    tif.i_irq_pending = '0;
    repeat (FC + 1) tick();
    tif.i_mie_wr = 1'b1;
    tif.i_mie_wdata = 1'b1;
    tick();
    tif.i_mie_wr = 1'b0;
    total_cnt++;
    if (tif.o_mie !== 1'b1 || tif.o_depth !== DW'(1))
      $display("FAIL nest_handler_mie: got mie=%b depth=%0d, required 1/1", tif.o_mie, tif.o_depth);
    else pass_cnt++;
    tif.i_irq_pending = 4'b0001;
    push_exp(5'd0, 1'b1);
    tick();
    tif.i_irq_pending = '0;
    repeat (FC + 1) tick();
    total_cnt++;
    if (tif.o_depth !== DW'(2) || tif.o_mie !== 1'b0 || tif.o_trap_mode !== 1'b1)
      $display("FAIL nest_depth2: got depth=%0d mie=%b mode=%b, required 2/0/1", tif.o_depth, tif.o_mie, tif.o_trap_mode);
    else pass_cnt++;
    tif.i_mret = 1'b1;
    tick();
    total_cnt++;
    if (tif.o_depth !== DW'(1) || tif.o_mie !== 1'b1)
      $display("FAIL nest_mret1: got depth=%0d mie=%b, required 1/1", tif.o_depth, tif.o_mie);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (tif.o_depth !== DW'(0) || tif.o_mie !== 1'b1 || tif.o_trap_mode !== 1'b0)
      $display("FAIL nest_mret2: got depth=%0d mie=%b mode=%b, required 0/1/0", tif.o_depth, tif.o_mie, tif.o_trap_mode);
    else pass_cnt++;
    tick();
    tif.i_mret = 1'b0;
    tif.i_irq_enable = '0;
    total_cnt++;
    if (tif.o_depth !== DW'(0) || tif.o_mie !== 1'b1 || tif.o_trap_mode !== 1'b0)
      $display("FAIL nest_mret_at0: got depth=%0d mie=%b mode=%b, required 0/1/0", tif.o_depth, tif.o_mie, tif.o_trap_mode);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    // Depth 1 with stack[0]=1 (MIE was 1 on entry).
    tif.i_exc_req = 1'b1;
    tif.i_exc_cause = 4'd5;
    push_exp(5'd5, 1'b0);
    tick();
    tif.i_exc_req = 1'b0;
    repeat (FC + 1) tick();
    tif.i_exc_req = 1'b1;
    tif.i_exc_cause = 4'd7;
    tif.i_mret = 1'b1;
    push_exp(5'd7, 1'b0);
    tick();
    tif.i_exc_req = 1'b0;
    tif.i_mret = 1'b0;
    repeat (FC + 1) tick();
    total_cnt++;
    if (tif.o_depth !== DW'(2))
      $display("FAIL simul_exc_mret: got depth=%0d, required 2", tif.o_depth);
    else pass_cnt++;
    tif.i_mret = 1'b1;
    tick();
    total_cnt++;
    if (tif.o_depth !== DW'(1) || tif.o_mie !== 1'b0)
      $display("FAIL simul_pop: got depth=%0d mie=%b, required 1/0", tif.o_depth, tif.o_mie);
    else pass_cnt++;
    tif.i_mie_wr = 1'b1;
    tif.i_mie_wdata = 1'b0;
    tick();
    tif.i_mret = 1'b0;
    tif.i_mie_wr = 1'b0;
    total_cnt++;
    if (tif.o_mie !== 1'b1 || tif.o_depth !== DW'(0))
      $display("FAIL simul_mret_wr: got mie=%b depth=%0d, required 1/0", tif.o_mie, tif.o_depth);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    tif.i_exc_req = 1'b1;
    tif.i_exc_cause = 4'd9;
    push_exp(5'd9, 1'b0);
    tick();
    repeat (FC + 1) tick();
    push_exp(5'd9, 1'b0);
    tick();
    tif.i_exc_req = 1'b0;
    repeat (FC + 1) tick();
    total_cnt++;
    if (tif.o_depth !== DW'(2) || tif.o_trap_mode !== 1'b1)
      $display("FAIL b2b_depth: got depth=%0d mode=%b, required 2/1", tif.o_depth, tif.o_trap_mode);
    else pass_cnt++;
  endtask

  task automatic test_double_fault();
    tif.i_exc_req = 1'b1;
    tif.i_exc_cause = 4'd6;
`ifndef TRAP_DOUBLE_FAULT_HALT_EN
    push_exp(5'd6, 1'b0);
`endif
    tick();
    tif.i_exc_req = 1'b0;
    repeat (FC + 3) tick();
`ifdef TRAP_DOUBLE_FAULT_HALT_EN
    total_cnt++;
    if (tif.o_halt !== 1'b1 || tif.o_flush !== 1'b1 || tif.o_cause !== 5'd6 || tif.o_depth !== DW'(2))
      $display("FAIL dfault_halt: got halt=%b flush=%b cause=%0d depth=%0d, required 1/1/6/2",
               tif.o_halt, tif.o_flush, tif.o_cause, tif.o_depth);
    else pass_cnt++;
    test_reset();
`else
    total_cnt++;
    if (tif.o_halt !== 1'b0 || tif.o_depth !== DW'(2) || tif.o_mie !== 1'b0 || tif.o_flush !== 1'b0 || tif.o_cause !== 5'd6)
      $display("FAIL dfault_sat: got halt=%b depth=%0d mie=%b flush=%b cause=%0d, required 0/2/0/0/6",
               tif.o_halt, tif.o_depth, tif.o_mie, tif.o_flush, tif.o_cause);
    else pass_cnt++;
    tif.i_mret = 1'b1;
    tick();
    tick();
    tif.i_mret = 1'b0;
    total_cnt++;
    if (tif.o_depth !== DW'(0))
      $display("FAIL dfault_unwind: got depth=%0d, required 0", tif.o_depth);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_flush();
    logic [13:0] outs;
    tif.i_exc_req = 1'b1;
    tif.i_exc_cause = 4'd11;
    tick();
    tif.i_exc_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    outs = {tif.o_trap_mode, tif.o_flush, tif.o_trap_take, tif.o_cause, tif.o_is_irq,
            tif.o_mie, 2'(tif.o_depth), tif.o_halt};
    total_cnt++;
    if (outs !== 14'd0) $display("FAIL reset_mid_flush: got %b, required all zero", outs);
    else pass_cnt++;
    repeat (FC + 3) tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_exception_single();
    test_irq_priority();
    test_nesting_mret();
    test_simultaneous();
    test_back_to_back();
    test_double_fault();
    test_reset_mid_flush();
    repeat (2) tick();
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending trap entries, required 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
